// File: rtl/zap_bus_arb_pkg.sv
// Shared types and constants for the ZAP bus arbiter.
//   state_t  : arbiter sequencing states
//   grant_t  : IDLE-cycle arbitration decision
//   SEL_WORD : full-word byte-lane mask used for instruction fetches
package zap_bus_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      BUS_D,
      BUS_I,
      DONE
   } state_t;

   typedef enum logic [1:0] {
      GNT_NONE,
      GNT_D,
      GNT_I
   } grant_t;

   localparam logic [3:0] SEL_WORD = 4'hF;

endpackage

// File: rtl/zap_bus_arbiter_if.sv
// Handshake bundle between the fetch/memory stages, the arbiter and the
// external ARM60-style bus. Signal prefixes are from the arbiter's view:
// i_* flow into the arbiter, o_* flow out of it.
//   slave  : arbiter side
//   master : requester + bus-responder side (stages / system bus / bench)
interface zap_bus_arbiter_if;

   logic        i_instr_stb;
   logic [31:0] i_instr_addr;
   logic        o_instr_ack;
   logic        o_instr_err;
   logic [31:0] o_instr_data;

   logic        i_data_stb;
   logic        i_data_wen;
   logic [31:0] i_data_addr;
   logic [3:0]  i_data_sel;
   logic [31:0] i_data_wdata;
   logic        o_data_ack;
   logic        o_data_err;
   logic [31:0] o_data_rdata;

   logic        o_bus_stb;
   logic        o_bus_we;
   logic [31:0] o_bus_addr;
   logic [3:0]  o_bus_sel;
   logic [31:0] o_bus_wdata;
   logic        i_bus_ack;
   logic        i_bus_err;
   logic [31:0] i_bus_rdata;

   modport slave (
      input  i_instr_stb, i_instr_addr,
      output o_instr_ack, o_instr_err, o_instr_data,
      input  i_data_stb, i_data_wen, i_data_addr, i_data_sel, i_data_wdata,
      output o_data_ack, o_data_err, o_data_rdata,
      output o_bus_stb, o_bus_we, o_bus_addr, o_bus_sel, o_bus_wdata,
      input  i_bus_ack, i_bus_err, i_bus_rdata
   );

   modport master (
      output i_instr_stb, i_instr_addr,
      input  o_instr_ack, o_instr_err, o_instr_data,
      output i_data_stb, i_data_wen, i_data_addr, i_data_sel, i_data_wdata,
      input  o_data_ack, o_data_err, o_data_rdata,
      input  o_bus_stb, o_bus_we, o_bus_addr, o_bus_sel, o_bus_wdata,
      output i_bus_ack, i_bus_err, i_bus_rdata
   );

endinterface

// File: rtl/zap_bus_timeout.sv
// Bus-hang watchdog: a TO_WDT-bit up-counter that clears on i_clr, counts
// while i_en is high, and flags o_expired once it reaches TIMEOUT_CYCLES.
//   i_clk, i_reset : clock, async active-high reset
//   i_clr          : synchronous clear (priority over i_en)
//   i_en           : count enable
//   o_expired      : counter == TIMEOUT_CYCLES
module zap_bus_timeout #(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int TO_WDT         = 8
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_clr,
   input  logic i_en,
   output logic o_expired
);

   logic [TO_WDT-1:0] cnt_q;
   logic [TO_WDT-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (i_clr)
         cnt_d = '0;
      else if (i_en && !o_expired)
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign o_expired = (cnt_q == TO_WDT'(TIMEOUT_CYCLES));

endmodule

// File: rtl/zap_bus_arbiter.sv
// Arbitrates the instruction-fetch and data ports onto the single external
// bus, one transaction at a time. Data has priority, except that after
// STARVE_LIMIT consecutive data grants with a fetch waiting, the fetch wins.
// A watchdog turns a hung access into an error response.
//   i_clk, i_reset : clock, async active-high reset
//   bus            : requester / bus handshake bundle (slave modport)
//
// state | meaning
// IDLE  | arbitrate; latch winner onto the bus outputs
// BUS_D | data access on the bus, waiting for ack/err/timeout
// BUS_I | fetch access on the bus, waiting for ack/err/timeout
// DONE  | mandatory dead cycle so requesters can drop their strobe
module zap_bus_arbiter
   import zap_bus_arb_pkg::*;
#(
   parameter int STARVE_LIMIT   = 4,
   parameter int TIMEOUT_CYCLES = 255,
   parameter int TO_WDT         = 8
) (
   input  logic              i_clk,
   input  logic              i_reset,
   zap_bus_arbiter_if.slave  bus
);

   localparam int SW = $clog2(STARVE_LIMIT + 1);

   state_t        state_q;
   grant_t        grant_d;
   logic [SW-1:0] starve_q;
   logic          to_expired;
   logic          xfer_err;

   logic          instr_ack_q, instr_err_q, data_ack_q, data_err_q;
   logic [31:0]   instr_data_q, data_rdata_q;
   logic          bus_stb_q, bus_we_q;
   logic [31:0]   bus_addr_q, bus_wdata_q;
   logic [3:0]    bus_sel_q;

   always_comb begin
      grant_d = GNT_NONE;
      if (state_q == IDLE) begin
         if (bus.i_data_stb && !(bus.i_instr_stb && starve_q == SW'(STARVE_LIMIT)))
            grant_d = GNT_D;
         else if (bus.i_instr_stb)
            grant_d = GNT_I;
      end
   end

   zap_bus_timeout #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .TO_WDT         (TO_WDT)
   ) u_timeout (
      .i_clk     (i_clk),
      .i_reset   (i_reset),
      .i_clr     (grant_d != GNT_NONE),
      .i_en      (state_q == BUS_D || state_q == BUS_I),
      .o_expired (to_expired)
   );

   // A timeout is indistinguishable from a bus error; err wins over ack.
   assign xfer_err = bus.i_bus_err | to_expired;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q      <= IDLE;
         starve_q     <= '0;
         instr_ack_q  <= 1'b0;
         instr_err_q  <= 1'b0;
         instr_data_q <= '0;
         data_ack_q   <= 1'b0;
         data_err_q   <= 1'b0;
         data_rdata_q <= '0;
         bus_stb_q    <= 1'b0;
         bus_we_q     <= 1'b0;
         bus_addr_q   <= '0;
         bus_sel_q    <= '0;
         bus_wdata_q  <= '0;
      end else begin
         instr_ack_q <= 1'b0;
         instr_err_q <= 1'b0;
         data_ack_q  <= 1'b0;
         data_err_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               if (grant_d == GNT_D) begin
                  state_q     <= BUS_D;
                  bus_stb_q   <= 1'b1;
                  bus_we_q    <= bus.i_data_wen;
                  bus_addr_q  <= bus.i_data_addr;
                  bus_sel_q   <= bus.i_data_sel;
                  bus_wdata_q <= bus.i_data_wdata;
                  if (!bus.i_instr_stb)
                     starve_q <= '0;
                  else if (starve_q != SW'(STARVE_LIMIT))
                     starve_q <= starve_q + 1'b1;
               end else if (grant_d == GNT_I) begin
                  state_q     <= BUS_I;
                  bus_stb_q   <= 1'b1;
                  bus_we_q    <= 1'b0;
                  bus_addr_q  <= bus.i_instr_addr;
                  bus_sel_q   <= SEL_WORD;
                  bus_wdata_q <= '0;
                  starve_q    <= '0;
               end
            end
            BUS_D: begin
               if (xfer_err) begin
                  state_q    <= DONE;
                  bus_stb_q  <= 1'b0;
                  data_err_q <= 1'b1;
               end else if (bus.i_bus_ack) begin
                  state_q      <= DONE;
                  bus_stb_q    <= 1'b0;
                  data_ack_q   <= 1'b1;
                  data_rdata_q <= bus.i_bus_rdata;
               end
            end
            BUS_I: begin
               if (xfer_err) begin
                  state_q     <= DONE;
                  bus_stb_q   <= 1'b0;
                  instr_err_q <= 1'b1;
               end else if (bus.i_bus_ack) begin
                  state_q      <= DONE;
                  bus_stb_q    <= 1'b0;
                  instr_ack_q  <= 1'b1;
                  instr_data_q <= bus.i_bus_rdata;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.o_instr_ack  = instr_ack_q;
   assign bus.o_instr_err  = instr_err_q;
   assign bus.o_instr_data = instr_data_q;
   assign bus.o_data_ack   = data_ack_q;
   assign bus.o_data_err   = data_err_q;
   assign bus.o_data_rdata = data_rdata_q;
   assign bus.o_bus_stb    = bus_stb_q;
   assign bus.o_bus_we     = bus_we_q;
   assign bus.o_bus_addr   = bus_addr_q;
   assign bus.o_bus_sel    = bus_sel_q;
   assign bus.o_bus_wdata  = bus_wdata_q;

endmodule

// File: tb/tb_zap_bus_arbiter.sv
module tb_zap_bus_arbiter;

   logic clk;
   logic rst;
   int   total;
   int   bad;
   int   n;

   zap_bus_arbiter_if bus_if ();

   zap_bus_arbiter #(
      .STARVE_LIMIT   (4),
      .TIMEOUT_CYCLES (255),
      .TO_WDT         (8)
   ) dut (
      .i_clk   (clk),
      .i_reset (rst),
      .bus     (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // grant order for both strobes held: 1 = instruction grant
   logic exp_i [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      bus_if.i_instr_stb  = 1'b1;
      bus_if.i_instr_addr = 32'h0000_8000;
      bus_if.i_data_stb   = 1'b1;
      bus_if.i_data_wen   = 1'b0;
      bus_if.i_data_addr  = 32'h0000_1004;
      bus_if.i_data_sel   = 4'hF;
      bus_if.i_data_wdata = 32'h0;
      bus_if.i_bus_ack    = 1'b0;
      bus_if.i_bus_err    = 1'b0;
      bus_if.i_bus_rdata  = 32'h0;

      // reset with requests present
      tick(); tick();
      chk("rst_stb",   32'(bus_if.o_bus_stb), 32'h0);
      chk("rst_addr",  bus_if.o_bus_addr, 32'h0);
      chk("rst_dack",  32'(bus_if.o_data_ack), 32'h0);
      chk("rst_iack",  32'(bus_if.o_instr_ack), 32'h0);
      chk("rst_rdata", bus_if.o_data_rdata, 32'h0);

      // zero-wait data read
      bus_if.i_instr_stb = 1'b0;
      rst = 1'b0;
      tick();
      chk("rd_stb",  32'(bus_if.o_bus_stb), 32'h1);
      chk("rd_addr", bus_if.o_bus_addr, 32'h0000_1004);
      chk("rd_we",   32'(bus_if.o_bus_we), 32'h0);
      bus_if.i_bus_ack   = 1'b1;
      bus_if.i_bus_rdata = 32'hDEAD_BEEF;
      tick();
      chk("rd_ack",    32'(bus_if.o_data_ack), 32'h1);
      chk("rd_rdata",  bus_if.o_data_rdata, 32'hDEAD_BEEF);
      chk("rd_stb_lo", 32'(bus_if.o_bus_stb), 32'h0);
      bus_if.i_bus_ack  = 1'b0;
      bus_if.i_data_stb = 1'b0;
      tick();
      chk("rd_ack_pulse", 32'(bus_if.o_data_ack), 32'h0);
      chk("rd_done_stb",  32'(bus_if.o_bus_stb), 32'h0);

      // both strobes held: starvation bound
      bus_if.i_instr_stb  = 1'b1;
      bus_if.i_instr_addr = 32'h0000_8000;
      bus_if.i_data_stb   = 1'b1;
      bus_if.i_data_wen   = 1'b1;
      bus_if.i_data_addr  = 32'h0000_D000;
      bus_if.i_data_sel   = 4'b0011;
      for (int i = 0; i < 10; i++) begin
         for (int k = 0; k < 10 && !bus_if.o_bus_stb; k++) tick();
         chk("ord_stb", 32'(bus_if.o_bus_stb), 32'h1);
         if (exp_i[i]) begin
            chk("ord_iaddr", bus_if.o_bus_addr, 32'h0000_8000);
            chk("ord_iwe",   32'(bus_if.o_bus_we), 32'h0);
            chk("ord_isel",  32'(bus_if.o_bus_sel), 32'hF);
         end else begin
            chk("ord_daddr", bus_if.o_bus_addr, 32'h0000_D000);
            chk("ord_dwe",   32'(bus_if.o_bus_we), 32'h1);
         end
         bus_if.i_bus_ack   = 1'b1;
         bus_if.i_bus_rdata = 32'hA000_0000 + 32'(i);
         tick();
         bus_if.i_bus_ack = 1'b0;
         if (exp_i[i]) chk("ord_iack", 32'(bus_if.o_instr_ack), 32'h1);
         else          chk("ord_dack", 32'(bus_if.o_data_ack), 32'h1);
      end
      bus_if.i_instr_stb = 1'b0;
      bus_if.i_data_stb  = 1'b0;
      tick(); tick();
      chk("ord_idata", bus_if.o_instr_data, 32'hA000_0009);

      // store with one wait state
      bus_if.i_data_stb   = 1'b1;
      bus_if.i_data_wen   = 1'b1;
      bus_if.i_data_sel   = 4'b1000;
      bus_if.i_data_addr  = 32'h0000_0200;
      bus_if.i_data_wdata = 32'h1122_3344;
      tick();
      bus_if.i_data_addr = 32'h0000_0BAD;
      chk("st_we",    32'(bus_if.o_bus_we), 32'h1);
      chk("st_sel",   32'(bus_if.o_bus_sel), 32'h8);
      chk("st_addr",  bus_if.o_bus_addr, 32'h0000_0200);
      chk("st_wdata", bus_if.o_bus_wdata, 32'h1122_3344);
      tick();
      chk("st_wait_ack", 32'(bus_if.o_data_ack), 32'h0);
      chk("st_wait_stb", 32'(bus_if.o_bus_stb), 32'h1);
      chk("st_addr_hold", bus_if.o_bus_addr, 32'h0000_0200);
      bus_if.i_bus_ack = 1'b1;
      tick();
      chk("st_ack", 32'(bus_if.o_data_ack), 32'h1);
      bus_if.i_bus_ack  = 1'b0;
      bus_if.i_data_stb = 1'b0;
      tick();

      // timeout
      bus_if.i_data_stb  = 1'b1;
      bus_if.i_data_wen  = 1'b0;
      bus_if.i_data_addr = 32'h0000_0300;
      tick();
      chk("to_stb", 32'(bus_if.o_bus_stb), 32'h1);
      n = 0;
      while (!bus_if.o_data_err && n < 400) begin
         tick();
         n++;
      end
      chk("to_cycles", 32'(n), 32'd256);
      chk("to_stb_lo", 32'(bus_if.o_bus_stb), 32'h0);
      chk("to_noack",  32'(bus_if.o_data_ack), 32'h0);
      bus_if.i_data_stb = 1'b0;
      tick();
      chk("to_err_pulse", 32'(bus_if.o_data_err), 32'h0);

      // ack and err together on a fetch
      bus_if.i_instr_stb  = 1'b1;
      bus_if.i_instr_addr = 32'h0000_0400;
      tick();
      chk("er_addr", bus_if.o_bus_addr, 32'h0000_0400);
      chk("er_sel",  32'(bus_if.o_bus_sel), 32'hF);
      bus_if.i_bus_ack   = 1'b1;
      bus_if.i_bus_err   = 1'b1;
      bus_if.i_bus_rdata = 32'h5555_5555;
      tick();
      chk("er_ierr",  32'(bus_if.o_instr_err), 32'h1);
      chk("er_iack",  32'(bus_if.o_instr_ack), 32'h0);
      chk("er_idata", bus_if.o_instr_data, 32'hA000_0009);
      bus_if.i_bus_ack   = 1'b0;
      bus_if.i_bus_err   = 1'b0;
      bus_if.i_instr_stb = 1'b0;
      tick();

      // reset during a wait-stated data transfer
      bus_if.i_data_stb  = 1'b1;
      bus_if.i_data_addr = 32'h0000_0500;
      tick();
      chk("mr_stb", 32'(bus_if.o_bus_stb), 32'h1);
      tick(); tick(); tick();
      rst = 1'b1;
      #1;
      chk("mr_async", 32'(bus_if.o_bus_stb), 32'h0);
      bus_if.i_data_stb = 1'b0;
      tick();
      rst = 1'b0;
      tick();
      chk("mr_noack", 32'(bus_if.o_data_ack), 32'h0);
      chk("mr_noerr", 32'(bus_if.o_data_err), 32'h0);
      bus_if.i_bus_ack = 1'b1;
      tick();
      chk("late_dack", 32'(bus_if.o_data_ack), 32'h0);
      chk("late_iack", 32'(bus_if.o_instr_ack), 32'h0);
      chk("late_stb",  32'(bus_if.o_bus_stb), 32'h0);
      bus_if.i_bus_ack    = 1'b0;
      bus_if.i_instr_stb  = 1'b1;
      bus_if.i_instr_addr = 32'h0000_0600;
      tick();
      chk("nf_addr", bus_if.o_bus_addr, 32'h0000_0600);
      bus_if.i_bus_ack   = 1'b1;
      bus_if.i_bus_rdata = 32'hCAFE_F00D;
      tick();
      chk("nf_iack",  32'(bus_if.o_instr_ack), 32'h1);
      chk("nf_idata", bus_if.o_instr_data, 32'hCAFE_F00D);
      bus_if.i_bus_ack   = 1'b0;
      bus_if.i_instr_stb = 1'b0;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
